// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port ids, size defaults.
package data_mem_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam int unsigned DW_DEFAULT           = 16;
    localparam int unsigned AW_DEFAULT           = 16;
    localparam int unsigned DEPTH_DEFAULT        = 256;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    // Addresses are widened to 32 bits by the caller so one helper serves any AW <= 32.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Starvation-aware priority picker: port 0 wins unless port 1 has lost STARVE_LIMIT times in a row.
module mem_arb_prio
    import data_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned CW           = $clog2(STARVE_LIMIT + 1)
) (
    input  logic          p0_req,
    input  logic          p1_req,
    input  logic [CW-1:0] starve_cnt,
    output logic          winner,
    output logic [CW-1:0] starve_cnt_next
);

    logic starved;

    always_comb begin
        starved = (starve_cnt == CW'(STARVE_LIMIT));
        winner  = (p1_req && (!p0_req || starved)) ? PORT_DMA : PORT_CPU;

        if (winner == PORT_DMA || !p1_req) begin
            starve_cnt_next = '0;
        end else if (starved) begin
            starve_cnt_next = starve_cnt;
        end else begin
            starve_cnt_next = starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer for the word data memory: one registered access per
// IDLE -> ACCESS -> DONE round, completion reported with a one-cycle ack.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int unsigned DW           = DW_DEFAULT,
    parameter int unsigned AW           = AW_DEFAULT,
    parameter int unsigned DEPTH        = DEPTH_DEFAULT,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_ack,
    output logic          p0_err,
    output logic [DW-1:0] p0_rdata,

    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    output logic          p1_err,
    output logic [DW-1:0] p1_rdata,

    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          win_q, win_d;
    logic          we_q, we_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          winner;
    logic [CW-1:0] starve_next;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_ok;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CW           (CW)
    ) u_prio (
        .p0_req          (p0_req),
        .p1_req          (p1_req),
        .starve_cnt      (starve_q),
        .winner          (winner),
        .starve_cnt_next (starve_next)
    );

    always_comb begin
        sel_we    = (winner == PORT_DMA) ? p1_we    : p0_we;
        sel_addr  = (winner == PORT_DMA) ? p1_addr  : p0_addr;
        sel_wdata = (winner == PORT_DMA) ? p1_wdata : p0_wdata;
        sel_ok    = addr_in_range(32'(sel_addr), DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        win_d       = win_q;
        we_d        = we_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    win_d    = winner;
                    we_d     = sel_we;
                    starve_d = starve_next;
                    if (sel_ok) begin
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        mem_read_d  = !sel_we;
                        mem_write_d = sel_we;
                        state_d     = StAccess;
                    end else begin
                        // Out-of-range requests never reach the memory pins.
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StAccess: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                ack_d       = 1'b1;
                rdata_d     = we_q ? '0 : mem_rdata;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d     = StIdle;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            win_q       <= win_d;
            we_q        <= we_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // ack/err/rdata are only non-zero in DONE, so steering by the latched winner suffices.
    assign p0_ack    = ack_q && (win_q == PORT_CPU);
    assign p0_err    = err_q && (win_q == PORT_CPU);
    assign p0_rdata  = (win_q == PORT_CPU) ? rdata_q : '0;
    assign p1_ack    = ack_q && (win_q == PORT_DMA);
    assign p1_err    = err_q && (win_q == PORT_DMA);
    assign p1_rdata  = (win_q == PORT_DMA) ? rdata_q : '0;

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: transaction scheduler model plus directed scenarios.
module tb_data_mem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [15:0] p0_rdata, p1_rdata;
    logic        mem_read, mem_write, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [256] = '{default: 16'h0};

    data_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_ack    (p0_ack),
        .p0_err    (p0_err),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_ack    (p1_ack),
        .p1_err    (p1_err),
        .p1_rdata  (p1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write commits on the falling edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(negedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          gk;
        int          ak;
        bit          port;
        bit          we;
        bit          err;
        logic [15:0] addr;
        logic [15:0] wdata;
    } ev_t;

    ev_t         evq[$];
    bit          grant_log[$];
    bit          ack_log[$];
    logic [15:0] shadow [256] = '{default: 16'h0};
    int          k = 0;
    int          free_k = 0;
    int          m_starve = 0;
    int          dbl_ack = 0;

    // Scheduler: one grant per free slot; in-range takes 3 cycles, error 2.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            k = 0;
            free_k = 0;
            m_starve = 0;
            evq.delete();
        end else begin
            k++;
            if (k >= free_k && (p0_req || p1_req)) begin
                ev_t e;
                e.port  = p1_req && (!p0_req || m_starve == LIMIT);
                e.we    = e.port ? p1_we : p0_we;
                e.addr  = e.port ? p1_addr : p0_addr;
                e.wdata = e.port ? p1_wdata : p0_wdata;
                e.err   = (e.addr >= 16'd256);
                e.gk    = k;
                e.ak    = e.err ? k : k + 1;
                free_k  = e.err ? k + 2 : k + 3;
                if (e.port || !p1_req) m_starve = 0;
                else if (m_starve < LIMIT) m_starve++;
                grant_log.push_back(e.port);
                evq.push_back(e);
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial forever begin
        logic        e_mr, e_mw, e_a0, e_a1, e_e0, e_e1, e_busy;
        logic [15:0] e_r0, e_r1;
        @(negedge clk);
        {e_mr, e_mw, e_a0, e_a1, e_e0, e_e1, e_busy} = '0;
        e_r0 = '0;
        e_r1 = '0;
        if (!rst_n) begin
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else if (evq.size() != 0) begin
            ev_t e;
            e = evq[0];
            e_busy = 1'b1;
            if (!e.err && e.gk == k) begin
                e_mr = !e.we;
                e_mw = e.we;
                chk("mem_addr", mem_addr, e.addr);
                if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
            end
            if (e.ak == k) begin
                logic [15:0] rd;
                rd = (e.we || e.err) ? 16'h0 : shadow[e.addr[7:0]];
                if (e.we && !e.err) shadow[e.addr[7:0]] = e.wdata;
                if (e.port) begin e_a1 = 1'b1; e_e1 = e.err; e_r1 = rd; end
                else        begin e_a0 = 1'b1; e_e0 = e.err; e_r0 = rd; end
                void'(evq.pop_front());
            end
        end
        chk("mem_read", mem_read, e_mr);
        chk("mem_write", mem_write, e_mw);
        chk("p0_ack", p0_ack, e_a0);
        chk("p1_ack", p1_ack, e_a1);
        chk("p0_err", p0_err, e_e0);
        chk("p1_err", p1_err, e_e1);
        chk("p0_rdata", p0_rdata, e_r0);
        chk("p1_rdata", p1_rdata, e_r1);
        chk("busy", busy, e_busy);
        if (p0_ack && p1_ack) dbl_ack++;
        if (p0_ack) ack_log.push_back(1'b0);
        if (p1_ack) ack_log.push_back(1'b1);
    end

    // ---------------- stimulus ----------------
    // Holds req until ack (bounded), then drops it in the ack cycle.
    task automatic issue(input bit port, input bit we, input logic [15:0] addr,
                         input logic [15:0] wdata, output int lat, output logic err,
                         output logic [15:0] rdata);
        int t0;
        bit got;
        @(negedge clk);
        if (port) begin p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wdata; end
        else      begin p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wdata; end
        t0 = k;
        got = 0;
        lat = -1;
        err = 1'bx;
        rdata = 'x;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) begin
                got = 1;
                lat = (k + 1) - (t0 + 1);
                err = port ? p1_err : p0_err;
                rdata = port ? p1_rdata : p0_rdata;
            end
        end
        if (port) p1_req = 0; else p0_req = 0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: port %0d got no ack want ack within 40 cycles", port);
        end
    endtask

    initial begin
        int          lat;
        logic        err;
        logic [15:0] rd;
        bit          exp_order [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // 1: reset with both requests held
        p0_req = 1; p0_we = 1; p0_addr = 16'h0005; p0_wdata = 16'h1111;
        p1_req = 1; p1_we = 0; p1_addr = 16'h0006;
        repeat (3) @(negedge clk);
        chk("t1_busy_in_reset", busy, 0);
        chk("t1_acks_in_reset", {p0_ack, p1_ack}, 0);
        rst_n = 1;
        @(negedge clk);
        chk("t1_first_edge_busy", busy, 1);
        chk("t1_first_edge_p0_write", {mem_read, mem_write}, 2'b01);
        begin
            bit got = 0;
            for (int i = 0; i < 10 && !got; i++) begin
                @(negedge clk);
                if (p0_ack) got = 1;
            end
            chk("t1_p0_ack_seen", got, 1);
        end
        p0_req = 0;
        p1_req = 0;

        // 2: write then read back
        issue(0, 1, 16'h0010, 16'hBEEF, lat, err, rd);
        chk("t2_write_latency", lat, 2);
        chk("t2_write_rdata", rd, 16'h0);
        issue(0, 0, 16'h0010, 16'h0, lat, err, rd);
        chk("t2_read_latency", lat, 2);
        chk("t2_read_err", err, 0);
        chk("t2_read_rdata", rd, 16'hBEEF);

        // 3: sustained contention
        repeat (2) @(negedge clk);
        ack_log.delete();
        grant_log.delete();
        dbl_ack = 0;
        fork
            begin
                int l; logic e; logic [15:0] r;
                for (int i = 0; i < 8; i++)
                    issue(0, 1, 16'(16'h0040 + i), 16'(16'h0100 + i), l, e, r);
            end
            begin
                int l; logic e; logic [15:0] r;
                for (int i = 0; i < 2; i++) issue(1, 0, 16'h0010, 16'h0, l, e, r);
            end
        join
        chk("t3_ack_count", ack_log.size(), 10);
        chk("t3_model_grants", grant_log.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < ack_log.size()) chk("t3_ack_order", ack_log[i], exp_order[i]);
            if (i < grant_log.size()) chk("t3_model_order", grant_log[i], exp_order[i]);
        end
        chk("t3_no_double_ack", dbl_ack, 0);

        // 4: out-of-range read
        issue(1, 0, 16'h0100, 16'h0, lat, err, rd);
        chk("t4_err", err, 1);
        chk("t4_rdata", rd, 16'h0);
        chk("t4_latency", lat, 1);

        // 5: reset in the middle of a write
        issue(0, 1, 16'h0020, 16'h5555, lat, err, rd);
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_addr = 16'h0020; p0_wdata = 16'h1234;
        @(posedge clk);
        #1;
        chk("t5_write_active", mem_write, 1);
        rst_n = 0;
        #1;
        chk("t5_write_dropped", mem_write, 0);
        chk("t5_busy_dropped", busy, 0);
        p0_req = 0;
        repeat (3) @(negedge clk);
        chk("t5_word_unchanged", mem[8'h20], 16'h5555);
        rst_n = 1;
        issue(0, 0, 16'h0020, 16'h0, lat, err, rd);
        chk("t5_readback", rd, 16'h5555);

        // 6: lone DMA read
        issue(0, 1, 16'h00FF, 16'hA5A5, lat, err, rd);
        issue(1, 0, 16'h00FF, 16'h0, lat, err, rd);
        chk("t6_latency", lat, 2);
        chk("t6_err", err, 0);
        chk("t6_rdata", rd, 16'hA5A5);
        chk("t6_dut_starve", dut.starve_q, 0);
        chk("t6_model_starve", m_starve, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running want finished");
        $fatal(1);
    end

endmodule
